// File: rtl/tile_scheduler.sv
// Layer sequencer for the systolic array: per weight tile it loads weights,
// switches them in, streams every input-feature tile, then drains the array.
module tile_scheduler #(
  parameter int CNT_W        = 8,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [CNT_W-1:0] job_w_tiles,
  input  logic [CNT_W-1:0] job_if_tiles,
  output logic             w_read,
  input  logic             w_done,
  output logic             if_read,
  input  logic             if_done,
  output logic             clr_w,
  output logic             clr_if,
  output logic             switch,
  output logic [CNT_W-1:0] w_tile_idx,
  output logic [CNT_W-1:0] if_tile_idx,
  output logic             busy,
  output logic             job_done
);

  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR_W, S_LOAD_W, S_SWITCH, S_CLR_IF, S_STREAM_IF, S_DRAIN, S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_w_tiles;
  logic [CNT_W-1:0] r_if_tiles;
  logic [CNT_W-1:0] r_w_idx;
  logic [CNT_W-1:0] r_if_idx;
  logic [DRN_W-1:0] r_drain;

  logic w_accept;
  logic w_zero_job;
  logic w_if_last;
  logic w_w_last;
  logic w_drain_end;

  // Last-index tests use count-1 so a full-scale count never wraps the compare.
  assign w_accept    = (r_state == S_IDLE) && job_valid;
  assign w_zero_job  = (job_w_tiles == '0) || (job_if_tiles == '0);
  assign w_if_last   = (r_if_idx == (r_if_tiles - CNT_W'(1)));
  assign w_w_last    = (r_w_idx == (r_w_tiles - CNT_W'(1)));
  assign w_drain_end = (r_drain == DRN_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    job_ready = 1'b0;
    clr_w     = 1'b0;
    w_read    = 1'b0;
    switch    = 1'b0;
    clr_if    = 1'b0;
    if_read   = 1'b0;
    job_done  = 1'b0;
    busy      = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        job_ready = 1'b1;
        busy      = 1'b0;
        if (job_valid) w_next = w_zero_job ? S_DONE : S_CLR_W;
      end
      S_CLR_W: begin
        clr_w  = 1'b1;
        w_next = S_LOAD_W;
      end
      S_LOAD_W: begin
        w_read = 1'b1;
        if (w_done) w_next = S_SWITCH;
      end
      S_SWITCH: begin
        switch = 1'b1;
        w_next = S_CLR_IF;
      end
      S_CLR_IF: begin
        clr_if = 1'b1;
        w_next = S_STREAM_IF;
      end
      S_STREAM_IF: begin
        if_read = 1'b1;
        if (if_done) w_next = w_if_last ? S_DRAIN : S_CLR_IF;
      end
      S_DRAIN: begin
        if (w_drain_end) w_next = w_w_last ? S_DONE : S_CLR_W;
      end
      S_DONE: begin
        job_done = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Tile indices are visible to the address generators, so they reset to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w_idx  <= '0;
      r_if_idx <= '0;
    end else if (w_accept) begin
      r_w_idx  <= '0;
      r_if_idx <= '0;
    end else if (r_state == S_STREAM_IF && if_done && !w_if_last) begin
      r_if_idx <= r_if_idx + CNT_W'(1);
    end else if (r_state == S_DRAIN && w_drain_end && !w_w_last) begin
      r_w_idx  <= r_w_idx + CNT_W'(1);
      r_if_idx <= '0;
    end
  end

  // Job counts and the drain timer are always rewritten before use.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_w_tiles  <= job_w_tiles;
      r_if_tiles <= job_if_tiles;
    end
    if (r_state == S_DRAIN) r_drain <= r_drain + DRN_W'(1);
    else                    r_drain <= '0;
  end

  assign w_tile_idx  = r_w_idx;
  assign if_tile_idx = r_if_idx;

endmodule

// File: tb/tb_tile_scheduler.sv
// Directed bench for tile_scheduler: reset, nominal, stray handshakes,
// zero counts, full-scale counts and mid-job abort.
module tb_tile_scheduler;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          job_valid = 1'b1;
  logic          job_ready;
  logic [CW-1:0] job_w_tiles = 3'd2;
  logic [CW-1:0] job_if_tiles = 3'd3;
  logic          w_read, w_done = 1'b0;
  logic          if_read, if_done = 1'b0;
  logic          clr_w, clr_if, switch;
  logic [CW-1:0] w_tile_idx, if_tile_idx;
  logic          busy, job_done;

  tile_scheduler #(.CNT_W(CW), .DRAIN_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_w_tiles(job_w_tiles), .job_if_tiles(job_if_tiles),
    .w_read(w_read), .w_done(w_done), .if_read(if_read), .if_done(if_done),
    .clr_w(clr_w), .clr_if(clr_if), .switch(switch),
    .w_tile_idx(w_tile_idx), .if_tile_idx(if_tile_idx),
    .busy(busy), .job_done(job_done)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [12:0] outs;
  assign outs = {w_read, if_read, clr_w, clr_if, switch, busy, job_done,
                 w_tile_idx, if_tile_idx};

  // Environment model and event log, both sampled on the falling edge.
  int t0 = 0;
  int lw = 1, lif = 1;
  bit stray = 1'b0;
  int n_clrw, n_sw, n_done, n_busy, n_burst, n_act;
  int done_rel, first_busy, ready_rel;
  int clrw_rel[8], clrw_widx[8], sw_rel[8], burst_log[64];

  initial begin
    int wc, ic, rel;
    bit prev_ifr;
    wc = 0; ic = 0; prev_ifr = 1'b0;
    forever begin
      @(negedge clk);
      rel = cyc - t0;
      if (clr_w) begin
        if (n_clrw < 8) begin clrw_rel[n_clrw] = rel; clrw_widx[n_clrw] = int'(w_tile_idx); end
        n_clrw++;
      end
      if (switch) begin
        if (n_sw < 8) sw_rel[n_sw] = rel;
        n_sw++;
      end
      if (job_done) begin n_done++; done_rel = rel; end
      if (busy) begin
        if (first_busy < 0) first_busy = rel;
        n_busy++;
      end
      if (if_read && !prev_ifr) begin
        if (n_burst < 64) burst_log[n_burst] = int'(w_tile_idx) * 8 + int'(if_tile_idx);
        n_burst++;
      end
      prev_ifr = if_read;
      if (w_read || if_read || clr_w || clr_if || switch) n_act++;
      if (w_read) begin wc++; w_done = (wc == lw); end
      else begin wc = 0; w_done = stray; end
      if (if_read) begin ic++; if_done = (ic == lif); end
      else begin ic = 0; if_done = stray; end
    end
  end

  task automatic run_job(input int w, input int f, input int lw_i, input int lif_i,
                         input bit stray_i, input int abort_at, input bit b2b);
    int rel;
    if (!b2b) @(negedge clk);
    lw = lw_i; lif = lif_i;
    n_clrw = 0; n_sw = 0; n_done = 0; n_busy = 0; n_burst = 0; n_act = 0;
    done_rel = -1; first_busy = -1; ready_rel = -1;
    job_w_tiles = w[CW-1:0];
    job_if_tiles = f[CW-1:0];
    job_valid = 1'b1;
    t0 = cyc;
    stray = stray_i;
    @(negedge clk);
    job_valid = 1'b0;
    job_w_tiles = ~job_w_tiles;
    job_if_tiles = ~job_if_tiles;
    for (rel = 1; rel < 3000; rel++) begin
      if (stray_i && rel == 10) begin job_valid = 1'b1; job_w_tiles = 3'd5; job_if_tiles = 3'd1; end
      if (stray_i && rel == 13) job_valid = 1'b0;
      if (rel == abort_at) rst = 1'b1;
      if (abort_at >= 0 && rel == abort_at + 1) begin rst = 1'b0; break; end
      if (job_ready) break;
      @(negedge clk);
    end
    ready_rel = rel;
    stray = 1'b0;
    if (abort_at < 0 && !job_ready) check("job_timeout", 0, 1);
  endtask

  task automatic check_nominal(input string tag);
    check({tag, "_done_cycle"}, done_rel, 57);
    check({tag, "_done_count"}, n_done, 1);
    check({tag, "_ready_cycle"}, ready_rel, 58);
    check({tag, "_clrw_count"}, n_clrw, 2);
    check({tag, "_clrw0"}, clrw_rel[0], 1);
    check({tag, "_clrw1"}, clrw_rel[1], 29);
    check({tag, "_widx_at29"}, clrw_widx[1], 1);
    check({tag, "_sw_count"}, n_sw, 2);
    check({tag, "_sw0"}, sw_rel[0], 6);
    check({tag, "_sw1"}, sw_rel[1], 34);
    check({tag, "_busy_first"}, first_busy, 1);
    check({tag, "_busy_cycles"}, n_busy, 57);
    check({tag, "_bursts"}, n_burst, 6);
    for (int i = 0; i < 6; i++) check({tag, "_burst_idx"}, burst_log[i], (i / 3) * 8 + (i % 3));
    check({tag, "_final_widx"}, int'(w_tile_idx), 1);
    check({tag, "_final_ifidx"}, int'(if_tile_idx), 2);
  endtask

  initial begin
    // Reset held three cycles with a job offered.
    repeat (3) begin
      @(negedge clk);
      check("rst_ready", int'(job_ready), 1);
      check("rst_outputs", int'(outs), 0);
    end
    rst = 1'b0;
    job_valid = 1'b0;
    @(negedge clk);
    check("post_rst_idle", int'(busy), 0);

    run_job(2, 3, 4, 5, 1'b0, -1, 1'b0);
    check_nominal("nom");

    // Back-to-back job with stray handshakes and a stray offer mid-job.
    run_job(2, 3, 4, 5, 1'b1, -1, 1'b1);
    check_nominal("stray");

    run_job(0, 5, 1, 1, 1'b0, -1, 1'b0);
    check("zero_done_cycle", done_rel, 1);
    check("zero_ready_cycle", ready_rel, 2);
    check("zero_done_count", n_done, 1);
    check("zero_activity", n_act, 0);

    run_job(3, 0, 1, 1, 1'b0, -1, 1'b0);
    check("zeroif_done_cycle", done_rel, 1);
    check("zeroif_activity", n_act, 0);

    run_job(7, 7, 1, 1, 1'b0, -1, 1'b0);
    check("max_bursts", n_burst, 49);
    check("max_switches", n_sw, 7);
    check("max_done_count", n_done, 1);
    check("max_done_cycle", done_rel, 148);
    check("max_last_burst", burst_log[48], 6 * 8 + 6);
    check("max_final_widx", int'(w_tile_idx), 6);
    check("max_final_ifidx", int'(if_tile_idx), 6);

    run_job(2, 3, 4, 5, 1'b0, 10, 1'b0);
    check("abort_ready", int'(job_ready), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_widx", int'(w_tile_idx), 0);
    check("abort_ifidx", int'(if_tile_idx), 0);
    repeat (10) @(negedge clk);
    check("abort_no_done", n_done, 0);
    check("abort_switches", n_sw, 1);
    check("abort_clrw", n_clrw, 1);

    run_job(2, 3, 4, 5, 1'b0, -1, 1'b0);
    check_nominal("after_abort");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tile_scheduler.md
# tile_scheduler

Layer-level sequencer for the systolic-array datapath. It accepts one convolution/GEMM job described as a count of weight tiles and input-feature tiles. For each weight tile it runs one weight load followed by every input-feature tile, then drains the array. It drives the datapath's buffer-read, clear and switch controls and reports the current tile indices to the address generators.

## Interface
Parameters:
- CNT_W, default 8: width of tile counts and tile indices.
- DRAIN_CYCLES, default 16: cycles spent in DRAIN after the last input tile of a weight tile. Must be ≥ 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- job_valid  in  1  job offered
- job_ready  out  1  scheduler idle and accepting a job
- job_w_tiles  in  CNT_W  number of weight tiles; sampled on accept
- job_if_tiles  in  CNT_W  input tiles per weight tile; sampled on accept
- w_read  out  1  weight buffer read enable
- w_done  in  1  weight tile fully read; honoured only in LOAD_W
- if_read  out  1  input-feature buffer read enable
- if_done  in  1  input tile fully read; honoured only in STREAM_IF
- clr_w  out  1  one-cycle clear of weight read pointers
- clr_if  out  1  one-cycle clear of input read pointers
- switch  out  1  one-cycle pulse that activates the freshly loaded weights
- w_tile_idx  out  CNT_W  current weight tile, 0-based
- if_tile_idx  out  CNT_W  current input tile, 0-based
- busy  out  1  high in every state except IDLE
- job_done  out  1  one-cycle pulse when the job finishes

## Operation
- States: IDLE, CLR_W, LOAD_W, SWITCH, CLR_IF, STREAM_IF, DRAIN, DONE.
- All control outputs are Moore-decoded from registered state:
  - job_ready = IDLE
  - clr_w = CLR_W
  - w_read = LOAD_W
  - switch = SWITCH
  - clr_if = CLR_IF
  - if_read = STREAM_IF
  - job_done = DONE
- IDLE: on job_valid && job_ready, latch both counts and zero both indices.
  - If either count is 0, go to DONE (no datapath activity).
  - Otherwise go to CLR_W.
- CLR_W → LOAD_W unconditionally.
- LOAD_W: stay until w_done = 1, then go to SWITCH.
- SWITCH → CLR_IF.
- CLR_IF → STREAM_IF.
- STREAM_IF: stay until if_done = 1, then:
  - if if_tile_idx < if_tiles−1: increment if_tile_idx and go to CLR_IF;
  - else go to DRAIN with drain counter = 0.
- DRAIN: increment the counter each cycle; after DRAIN_CYCLES cycles:
  - if w_tile_idx < w_tiles−1: increment w_tile_idx, zero if_tile_idx, go to CLR_W;
  - else go to DONE.
- DONE → IDLE.
- Indices hold their final values in DONE and IDLE until the next accept.
- Ignoring stray inputs:
  - w_done outside LOAD_W is ignored; if_done outside STREAM_IF is ignored.
  - w_done and if_done both high in LOAD_W: only w_done acts.
- job_valid outside IDLE is ignored. Count inputs may change freely after the accept cycle.
- Counters are unsigned CNT_W bits. The maximum count (2^CNT_W−1) must complete without wrap: compare against count−1, never against count.

## Timing
- Reset: after the first rising edge with rst = 1, the state is IDLE.
  - job_ready = 1.
  - All other outputs are 0, including both indices, busy and job_done.
- Reset mid-job aborts immediately. No switch or job_done is emitted; latched counts are discarded.
- Accept edge = cycle 0. CLR_W occupies cycle 1, so clr_w is high in cycle 1.
- Per-weight-tile duration: 1 (CLR_W) + Lw + 1 (SWITCH) + if_tiles·(1 + Lif) + DRAIN_CYCLES.
  - Lw = LOAD_W cycles, counting the cycle in which w_done is seen.
  - Lif is defined the same way for STREAM_IF and if_done.
- job_done is high one cycle after the final DRAIN cycle. job_ready rises the following cycle.
- Back-to-back jobs: a new job is accepted on the first IDLE cycle, with no extra bubble.
- A zero-count job: job_done in cycle 1, job_ready in cycle 2.
- w_done/if_done that is already high on the first cycle of LOAD_W/STREAM_IF gives Lw/Lif = 1.

## Test plan
- Reset: hold rst 3 cycles with job_valid = 1 → job_ready = 1, all other outputs 0, no accept while rst is high.
- Nominal job: DRAIN_CYCLES = 4, w_tiles = 2, if_tiles = 3; w_done 4 cycles after w_read rises, if_done 5 cycles after each if_read rises. Required response:
  - clr_w in cycles 1 and 29; switch in cycles 6 and 34;
  - if_tile_idx steps 0, 1, 2 within each weight tile; w_tile_idx = 1 from cycle 29;
  - job_done exactly in cycle 57; busy high in cycles 1–57.
- Zero count: w_tiles = 0, if_tiles = 5 → job_done in cycle 1, no w_read/if_read/switch/clr pulse at any time.
- Stray handshakes: pulse w_done during STREAM_IF and if_done during LOAD_W, and set job_valid with different counts mid-job → cycle count and indices identical to the nominal run.
- Max counts: CNT_W = 3, w_tiles = 7, if_tiles = 7, Lw = Lif = 1 → 49 if_read tiles, 7 switch pulses, final indices 6/6, single job_done.
- Abort: assert rst in cycle 10 of the nominal job → IDLE next edge, no job_done. A job accepted afterwards runs the full nominal sequence.
